// File: rtl/hll_pkg.sv
// Shared types and sizing for the HLL k-mer front end.
package hll_pkg;

  localparam int unsigned KMER_K     = 31;
  localparam int unsigned KMER_W     = 2 * KMER_K;
  localparam int unsigned PIPE_LAT   = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FILL_W     = $clog2(KMER_K + 1);
  localparam int unsigned CREDIT_W   = $clog2(FIFO_DEPTH + 1);

  typedef logic [KMER_W-1:0] kmer_t;
  typedef logic [1:0]        base_t;

  localparam base_t BASE_A = 2'd0;
  localparam base_t BASE_C = 2'd1;
  localparam base_t BASE_G = 2'd2;
  localparam base_t BASE_T = 2'd3;

  typedef enum logic {FLUSH, RUN} sched_state_e;

  typedef struct packed {
    logic  last;
    kmer_t kmer;
  } kmer_entry_t;

endpackage

// File: rtl/kmer_fifo.sv
// Synchronous FIFO with a registered head (show-ahead) output.
// Optional KMER_SCHED_STATS_EN adds an overflow assertion.
module kmer_fifo #(
  parameter int unsigned WIDTH = 63,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] count_next;
  logic             pop;

  always_comb begin
    pop         = rd_en && rd_valid;
    rd_ptr_next = rd_ptr + PTR_W'(pop);
    remain      = count - CNT_W'(pop);
    count_next  = remain + CNT_W'(wr_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Head register reloads from storage, or bypasses the write when the FIFO drains to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rd_valid <= (count_next != '0);
      if (remain == '0) begin
        if (wr_en) rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_ptr_next];
      end
    end
  end

`ifdef KMER_SCHED_STATS_EN
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(wr_en && count == CNT_W'(DEPTH)))
        else $error("kmer_fifo write while full");
    end
  end
`endif

endmodule

// File: rtl/kmer_window_scheduler.sv
// Sliding K-base window feeding the canonical_kmer pipe under FIFO credits.
// Define KMER_SCHED_STATS_EN for issue/N-base counters and credit assertions.
module kmer_window_scheduler
  import hll_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  base_t       s_base,
  input  logic        s_is_n,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output kmer_t       ck_data,
  output logic        ck_valid,
  input  kmer_t       ck_out_data,
  input  logic        ck_out_valid,
  output kmer_t       m_kmer,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] stat_kmers,
  output logic [31:0] stat_nbases
);

  localparam int unsigned FLUSH_W = $clog2(PIPE_LAT);

  sched_state_e        state;
  sched_state_e        state_next;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [FLUSH_W-1:0]  flush_cnt_next;
  kmer_t               win;
  kmer_t               win_next;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_next;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_next;
  logic                ck_last;
  logic [PIPE_LAT-1:0] last_sr;
  logic                accept;
  logic                push_base;
  logic                issue;
  logic                pop;
  logic                fifo_wr;
  kmer_entry_t         wr_entry;
  kmer_entry_t         rd_entry;

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    win_next       = win;
    fill_next      = fill;

    accept    = s_valid && s_ready;
    push_base = accept && !s_is_n;
    issue     = push_base && (fill >= FILL_W'(KMER_K - 1));
    pop       = m_valid && m_ready;

    // Hold off input until any pre-reset results have drained out of the pipe.
    if (state == FLUSH) begin
      flush_cnt_next = flush_cnt + FLUSH_W'(1);
      if (flush_cnt == FLUSH_W'(PIPE_LAT - 1)) state_next = RUN;
    end

    if (push_base) begin
      win_next  = {win[KMER_W-3:0], s_base};
      fill_next = (fill == FILL_W'(KMER_K)) ? fill : fill + FILL_W'(1);
    end else if (accept) begin
      fill_next = '0;
    end
    if (accept && s_last) fill_next = '0;

    credit_next = credit - CREDIT_W'(issue) + CREDIT_W'(pop);
    fifo_wr     = ck_out_valid && (state == RUN);
    wr_entry    = '{last: last_sr[PIPE_LAT-1], kmer: ck_out_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      win       <= '0;
      fill      <= '0;
      credit    <= CREDIT_W'(FIFO_DEPTH);
      s_ready   <= 1'b0;
      ck_valid  <= 1'b0;
      ck_data   <= '0;
      ck_last   <= 1'b0;
      last_sr   <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      win       <= win_next;
      fill      <= fill_next;
      credit    <= credit_next;
      s_ready   <= (state_next == RUN) && (credit_next != '0);
      ck_valid  <= issue;
      ck_last   <= issue && s_last;
      if (issue) ck_data <= win_next;
      // Last flag rides alongside the fixed-latency pipe.
      last_sr   <= {last_sr[PIPE_LAT-2:0], ck_last};
    end
  end

  kmer_fifo #(
    .WIDTH($bits(kmer_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (m_ready),
    .rd_data (rd_entry),
    .rd_valid(m_valid)
  );

  assign m_kmer = rd_entry.kmer;
  assign m_last = rd_entry.last;

`ifdef KMER_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_kmers  <= '0;
      stat_nbases <= '0;
    end else begin
      stat_kmers  <= stat_kmers + 32'(issue);
      stat_nbases <= stat_nbases + 32'(accept && s_is_n);
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (credit <= CREDIT_W'(FIFO_DEPTH))
        else $error("credit above FIFO depth");
      assert (!(issue && credit == '0))
        else $error("credit underflow");
    end
  end
`else
  assign stat_kmers  = '0;
  assign stat_nbases = '0;
`endif

endmodule

// File: tb/tb_kmer_window_scheduler.sv
// Directed bench for kmer_window_scheduler with a behavioural canonical_kmer pipe.
module tb_kmer_window_scheduler;
  import hll_pkg::*;

`ifdef KMER_SCHED_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  base_t       s_base = '0;
  logic        s_is_n = 1'b0;
  logic        s_last = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  kmer_t       ck_data;
  logic        ck_valid;
  kmer_t       ck_out_data;
  logic        ck_out_valid;
  kmer_t       m_kmer;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] stat_kmers;
  logic [31:0] stat_nbases;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned acc_cnt = 0;
  int unsigned acc0;
  int unsigned seen;
  logic [KMER_W:0] got_q[$];
  logic [KMER_W:0] exp_q[$];
  base_t           hist[$];

  kmer_window_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .s_base(s_base), .s_is_n(s_is_n), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .ck_data(ck_data), .ck_valid(ck_valid), .ck_out_data(ck_out_data), .ck_out_valid(ck_out_valid),
    .m_kmer(m_kmer), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .stat_kmers(stat_kmers), .stat_nbases(stat_nbases)
  );

  always #5 clk = ~clk;

  function automatic kmer_t canon(input kmer_t fwd);
    kmer_t rc;
    for (int i = 0; i < KMER_K; i++) rc[2*i +: 2] = 2'd3 - fwd[2*(KMER_K-1-i) +: 2];
    return (fwd < rc) ? fwd : rc;
  endfunction

  function automatic base_t pat(input int i);
    return base_t'((i * 5 + i / 3) % 4);
  endfunction

  // Non-resettable fixed-latency canonicaliser, as the real datapath behaves.
  kmer_t               pd [PIPE_LAT];
  logic [PIPE_LAT-1:0] pv = '0;
  always @(posedge clk) begin
    pv    <= {pv[PIPE_LAT-2:0], ck_valid};
    pd[0] <= canon(ck_data);
    for (int i = 1; i < PIPE_LAT; i++) pd[i] <= pd[i-1];
  end
  assign ck_out_valid = pv[PIPE_LAT-1];
  assign ck_out_data  = pd[PIPE_LAT-1];

  always @(posedge clk) begin
    if (rst_n && s_valid && s_ready) acc_cnt <= acc_cnt + 1;
    if (rst_n && m_valid && m_ready) got_q.push_back({m_last, m_kmer});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic model_accept(input base_t b, input logic n, input logic last);
    kmer_t k;
    if (n) hist.delete();
    else begin
      hist.push_back(b);
      if (hist.size() >= KMER_K) begin
        k = '0;
        for (int i = hist.size() - KMER_K; i < hist.size(); i++) k = {k[KMER_W-3:0], hist[i]};
        exp_q.push_back({last, canon(k)});
      end
    end
    if (last) hist.delete();
  endtask

  task automatic send(input base_t b, input logic n, input logic last);
    int unsigned waited;
    @(negedge clk);
    s_base = b; s_is_n = n; s_last = last; s_valid = 1'b1;
    waited = 0;
    while (!s_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) chk("send_timeout", 64'(s_ready), 64'd1);
    else begin
      @(posedge clk);
      model_accept(b, n, last);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0; s_is_n = 1'b0; s_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; s_is_n = 1'b0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete(); hist.delete();
  endtask

  task automatic wait_drain(input int unsigned n);
    for (int c = 0; c < 400 && got_q.size() < n; c++) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and flush window.
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_ck_valid", 64'(ck_valid), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_stat_kmers", 64'(stat_kmers), 64'd0);
    chk("rst_stat_nbases", 64'(stat_nbases), 64'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= PIPE_LAT; i++) begin
      @(negedge clk);
      chk("flush_s_ready", 64'(s_ready), 64'(i == PIPE_LAT));
    end

    // 1: single ACGT k-mer and its latency.
    m_ready = 1'b1;
    for (int i = 0; i < 31; i++) send(base_t'(i % 4), 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t1_ck_valid", 64'(ck_valid), 64'd1);
    chk("t1_ck_data", 64'(ck_data), 64'h06C6_C6C6_C6C6_C6C6);
    repeat (8) @(negedge clk);
    chk("t1_m_valid_early", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("t1_m_valid", 64'(m_valid), 64'd1);
    chk("t1_m_kmer", 64'(m_kmer), 64'h06C6_C6C6_C6C6_C6C6);
    repeat (5) @(negedge clk);
    chk("t1_count", 64'(got_q.size()), 64'd1);

    // 2: 40 A bases give 10 zero k-mers.
    do_reset(); repeat (PIPE_LAT) @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) send(BASE_A, 1'b0, 1'b0);
    idle(); wait_drain(10); repeat (5) @(negedge clk);
    chk("t2_count", 64'(got_q.size()), 64'd10);
    for (int i = 0; i < got_q.size(); i++) chk("t2_kmer", 64'(got_q[i]), 64'd0);
    chk("t2_stat_kmers", 64'(stat_kmers), 64'(STATS * 10));

    // 3: N at index 19 leaves too few bases for any k-mer.
    do_reset(); repeat (PIPE_LAT) @(negedge clk);
    for (int i = 0; i < 40; i++) send(BASE_G, i == 19, 1'b0);
    idle(); repeat (20) @(negedge clk);
    chk("t3_count", 64'(got_q.size()), 64'd0);
    chk("t3_stat_nbases", 64'(stat_nbases), 64'(STATS));
    chk("t3_stat_kmers", 64'(stat_kmers), 64'd0);

    // 4: backpressure fills the FIFO, then everything drains in order.
    do_reset(); repeat (PIPE_LAT) @(negedge clk);
    m_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 46; i++) send(pat(i), 1'b0, 1'b0);
    @(negedge clk);
    s_base = pat(46); s_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_stall_ready", 64'(s_ready), 64'd0);
    chk("t4_accepts", 64'(acc_cnt - acc0), 64'd46);
    chk("t4_no_pop", 64'(got_q.size()), 64'd0);
    chk("t4_head_valid", 64'(m_valid), 64'd1);
    if (exp_q.size() > 0) chk("t4_head_hold", 64'({m_last, m_kmer}), 64'(exp_q[0]));
    m_ready = 1'b1;
    for (int i = 46; i < 100; i++) send(pat(i), 1'b0, 1'b0);
    idle(); wait_drain(70); repeat (5) @(negedge clk);
    chk("t4_count", 64'(got_q.size()), 64'd70);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("t4_order", 64'(got_q[i]), 64'(exp_q[i]));

    // 5: two reads, window restarts at the read boundary.
    do_reset(); repeat (PIPE_LAT) @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 31; i++) send(base_t'(i % 4), 1'b0, i == 30);
    for (int i = 0; i < 31; i++) send(BASE_C, 1'b0, 1'b0);
    idle(); wait_drain(2); repeat (5) @(negedge clk);
    chk("t5_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() >= 2) begin
      chk("t5_read1", 64'(got_q[0]), 64'({1'b1, 62'h06C6_C6C6_C6C6_C6C6}));
      chk("t5_read2", 64'(got_q[1]), 64'({1'b0, 62'h1555_5555_5555_5555}));
    end

    // 6: reset with 5 k-mers in flight.
    do_reset(); repeat (PIPE_LAT) @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 35; i++) send(base_t'(i % 4), 1'b0, 1'b0);
    do_reset();
    chk("t6_ready_rel", 64'(s_ready), 64'd0);
    for (int i = 1; i <= PIPE_LAT; i++) begin
      @(negedge clk);
      chk("t6_flush_ready", 64'(s_ready), 64'(i == PIPE_LAT));
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    chk("t6_stale_valid", 64'(seen), 64'd0);
    chk("t6_stale_count", 64'(got_q.size()), 64'd0);
    m_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 46; i++) send(pat(i), 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    chk("t6_credit_accepts", 64'(acc_cnt - acc0), 64'd46);
    chk("t6_credit_ready", 64'(s_ready), 64'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
